// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port (icache/dcache) memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam int P_ICACHE = 0;
    localparam int P_DCACHE = 1;

    localparam int DEFAULT_DATA_W = 256;
    localparam int DEFAULT_ADDR_W = 32;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that was not granted last time.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    always_comb begin
        grant_valid = |req;
        grant_idx   = 1'b0;
        if (req[P_ICACHE] && req[P_DCACHE]) begin
            grant_idx = ~last_grant;
        end else if (req[P_DCACHE]) begin
            grant_idx = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates line fills / write-backs from icache (port 0) and dcache (port 1)
// onto a single memory port, with a sticky no-ack timeout flag.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              p0_enable_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_data_i,
    output logic [DATA_W-1:0] p0_data_o,
    output logic              p0_ack_o,

    input  logic              p1_enable_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_data_i,
    output logic [DATA_W-1:0] p1_data_o,
    output logic              p1_ack_o,

    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,

    output logic              err_o
);

    localparam int               CNT_W       = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ERR_EDGE    = CNT_W'(TIMEOUT - 1);

    arb_state_t        state;
    arb_state_t        state_next;
    logic              last_grant;
    logic              grant_q;
    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic [CNT_W-1:0]  wait_cnt;
    logic              err_q;

    logic              grant_valid;
    logic              grant_idx;
    logic              take_grant;
    logic              mem_done;
    logic              busy_stall;

    mem_arb_rr u_rr (
        .req         ({p1_enable_i, p0_enable_i}),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Requests are only looked at in IDLE and acks only in BUSY, so stray
    // acks in the bubble or after a reset fall through harmlessly.
    always_comb begin
        state_next = state;
        take_grant = 1'b0;
        mem_done   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_next = BUSY;
                    take_grant = 1'b1;
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    state_next = RELEASE;
                    mem_done   = 1'b1;
                end
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy_stall = (state == BUSY) && !mem_ack_i;

    // last_grant resets to port 1 so the icache wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_q    <= 1'b0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_data   <= '0;
            wait_cnt   <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_next;
            if (take_grant) begin
                last_grant <= grant_idx;
                grant_q    <= grant_idx;
                lat_write  <= grant_idx ? p1_write_i : p0_write_i;
                lat_addr   <= grant_idx ? p1_addr_i  : p0_addr_i;
                lat_data   <= grant_idx ? p1_data_i  : p0_data_i;
                wait_cnt   <= '0;
            end else if (busy_stall && wait_cnt != TIMEOUT_CNT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            // Flag rises on the same edge the counter lands on TIMEOUT.
            if (busy_stall && wait_cnt == ERR_EDGE) begin
                err_q <= 1'b1;
            end
        end
    end

    assign mem_enable_o = (state == BUSY);
    assign mem_write_o  = lat_write;
    assign mem_addr_o   = lat_addr;
    assign mem_data_o   = lat_data;

    assign p0_ack_o  = mem_done && (grant_q == 1'(P_ICACHE));
    assign p1_ack_o  = mem_done && (grant_q == 1'(P_DCACHE));
    assign p0_data_o = p0_ack_o ? mem_data_i : '0;
    assign p1_data_o = p1_ack_o ? mem_data_i : '0;

    assign err_o = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a cycle-indexed transaction model predicts
// memory-side transactions and port acks; a negedge monitor checks the DUT.
module tb_mem_arbiter;

    localparam int DW    = 256;
    localparam int AW    = 32;
    localparam int TO    = 64;
    localparam int NEVER = 32'h7fff_ffff;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            start;
    } mem_txn_t;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        int            cyc;
    } ack_txn_t;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          p0_enable_i, p0_write_i, p0_ack_o;
    logic [AW-1:0] p0_addr_i;
    logic [DW-1:0] p0_data_i, p0_data_o;
    logic          p1_enable_i, p1_write_i, p1_ack_o;
    logic [AW-1:0] p1_addr_i;
    logic [DW-1:0] p1_data_i, p1_data_o;
    logic          mem_enable_o, mem_write_o, mem_ack_i, err_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o, mem_data_i;

    mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .p0_enable_i  (p0_enable_i),
        .p0_write_i   (p0_write_i),
        .p0_addr_i    (p0_addr_i),
        .p0_data_i    (p0_data_i),
        .p0_data_o    (p0_data_o),
        .p0_ack_o     (p0_ack_o),
        .p1_enable_i  (p1_enable_i),
        .p1_write_i   (p1_write_i),
        .p1_addr_i    (p1_addr_i),
        .p1_data_i    (p1_data_i),
        .p1_data_o    (p1_data_o),
        .p1_ack_o     (p1_ack_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    mem_txn_t mem_q[$];
    ack_txn_t ack_q[$];

    // Requester and memory model state, all in terms of cycle numbers.
    bit            outstanding[2];
    bit            drop_en[2];
    logic          drv_write[2];
    logic [AW-1:0] drv_addr[2];
    logic [DW-1:0] drv_data[2];
    bit            busy;
    int            busy_port, busy_start, ack_at, free_cyc, waited;
    int            last_served, err_set_cyc;
    int            next_delay;
    bit            rand_delay, scramble, spurious, force_ack, do_rst;
    bit            fixed_data;
    logic [DW-1:0] fixed_data_val;

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] act,
                               input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic issue(input int p, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        outstanding[p] = 1'b1;
        drop_en[p]     = 1'b0;
        drv_write[p]   = w;
        drv_addr[p]    = a;
        drv_data[p]    = d;
    endtask

    // One call per cycle: drive inputs just after the edge and advance the model.
    task automatic applyStimulus(input int n);
        for (int s = 0; s < n; s++) begin
            int k;
            int w;
            bit en[2];
            mem_txn_t t;
            ack_txn_t a;
            @(posedge clk);
            #1;
            k          = cyc;
            rst_i      = do_rst;
            mem_ack_i  = 1'b0;
            mem_data_i = fixed_data ? fixed_data_val : rand_line();
            if (do_rst) begin
                busy        = 1'b0;
                free_cyc    = k + 1;
                last_served = 1;
                for (int p = 0; p < 2; p++) begin
                    outstanding[p] = 1'b0;
                    drop_en[p]     = 1'b0;
                end
            end else if (busy) begin
                if (k >= ack_at) begin
                    mem_ack_i = 1'b1;
                    a.port    = busy_port;
                    a.data    = mem_data_i;
                    a.cyc     = k;
                    ack_q.push_back(a);
                    busy                   = 1'b0;
                    free_cyc               = k + 2;
                    outstanding[busy_port] = 1'b0;
                    drop_en[busy_port]     = 1'b0;
                end else begin
                    waited++;
                    if (waited == TO && err_set_cyc == NEVER) err_set_cyc = k + 1;
                end
            end else begin
                mem_ack_i = force_ack || (spurious && $urandom_range(3) == 0);
            end
            if (busy && scramble) begin
                drv_write[busy_port] = 1'($urandom_range(1));
                drv_addr[busy_port]  = $urandom;
                drv_data[busy_port]  = rand_line();
                drop_en[busy_port]   = 1'($urandom_range(1));
            end
            for (int p = 0; p < 2; p++) en[p] = outstanding[p] && !drop_en[p];
            p0_enable_i = en[0];
            p0_write_i  = drv_write[0];
            p0_addr_i   = drv_addr[0];
            p0_data_i   = drv_data[0];
            p1_enable_i = en[1];
            p1_write_i  = drv_write[1];
            p1_addr_i   = drv_addr[1];
            p1_data_i   = drv_data[1];
            if (!do_rst && !busy && k >= free_cyc && (en[0] || en[1])) begin
                if (en[0] && en[1]) w = (last_served == 0) ? 1 : 0;
                else                w = en[0] ? 0 : 1;
                last_served = w;
                busy        = 1'b1;
                busy_port   = w;
                busy_start  = k + 1;
                waited      = 0;
                ack_at      = k + 1 + (rand_delay ? int'($urandom_range(5)) : next_delay);
                t.write     = drv_write[w];
                t.addr      = drv_addr[w];
                t.data      = drv_data[w];
                t.start     = k + 1;
                mem_q.push_back(t);
            end
        end
    endtask

    bit       active   = 1'b0;
    bit       lat_zero = 1'b0;
    mem_txn_t cur;

    // Monitor: consumes predicted transactions as the DUT presents them.
    always @(negedge clk) begin
        ack_txn_t      got;
        logic          exp_a0, exp_a1;
        logic [DW-1:0] exp_d0, exp_d1;
        bit            ending;
        if (mem_q.size() > 0 && mem_q[0].start == cyc) begin
            cur      = mem_q.pop_front();
            active   = 1'b1;
            lat_zero = 1'b0;
        end
        checkOutput("mem_enable", DW'(mem_enable_o), DW'(active));
        if (active) begin
            checkOutput("mem_write", DW'(mem_write_o), DW'(cur.write));
            checkOutput("mem_addr", DW'(mem_addr_o), DW'(cur.addr));
            checkOutput("mem_data", mem_data_o, cur.data);
        end else if (lat_zero) begin
            checkOutput("rst_write", DW'(mem_write_o), '0);
            checkOutput("rst_addr", DW'(mem_addr_o), '0);
            checkOutput("rst_data", mem_data_o, '0);
        end
        exp_a0 = 1'b0;
        exp_a1 = 1'b0;
        exp_d0 = '0;
        exp_d1 = '0;
        ending = 1'b0;
        if (ack_q.size() > 0 && ack_q[0].cyc == cyc) begin
            got    = ack_q.pop_front();
            ending = 1'b1;
            if (got.port == 0) begin
                exp_a0 = 1'b1;
                exp_d0 = got.data;
            end else begin
                exp_a1 = 1'b1;
                exp_d1 = got.data;
            end
        end
        checkOutput("p0_ack", DW'(p0_ack_o), DW'(exp_a0));
        checkOutput("p1_ack", DW'(p1_ack_o), DW'(exp_a1));
        checkOutput("p0_data", p0_data_o, exp_d0);
        checkOutput("p1_data", p1_data_o, exp_d1);
        checkOutput("err", DW'(err_o), DW'(cyc >= err_set_cyc));
        if (ending || rst_i) active = 1'b0;
        if (rst_i) lat_zero = 1'b1;
    end

    initial begin
        int guard;
        rst_i = 1'b1;
        p0_enable_i = 1'b0; p0_write_i = 1'b0; p0_addr_i = '0; p0_data_i = '0;
        p1_enable_i = 1'b0; p1_write_i = 1'b0; p1_addr_i = '0; p1_data_i = '0;
        mem_ack_i = 1'b0; mem_data_i = '0;
        for (int p = 0; p < 2; p++) begin
            outstanding[p] = 1'b0; drop_en[p] = 1'b0;
            drv_write[p] = 1'b0; drv_addr[p] = '0; drv_data[p] = '0;
        end
        busy = 1'b0; free_cyc = 0; last_served = 1; err_set_cyc = NEVER;
        next_delay = 3; rand_delay = 1'b0; scramble = 1'b0; spurious = 1'b0;
        force_ack = 1'b0; fixed_data = 1'b0; fixed_data_val = '0;
        do_rst = 1'b1;
        applyStimulus(3);
        do_rst = 1'b0;

        // Single icache fill acked ten cycles into BUSY with an A5 pattern.
        fixed_data     = 1'b1;
        fixed_data_val = {32{8'hA5}};
        next_delay     = 10;
        issue(0, 1'b0, 32'h100, '0);
        applyStimulus(20);
        fixed_data = 1'b0;

        // Tie straight after reset: icache first, dcache next, then icache again.
        do_rst = 1'b1;
        applyStimulus(1);
        do_rst     = 1'b0;
        next_delay = 4;
        issue(0, 1'b0, 32'h40, rand_line());
        issue(1, 1'b1, 32'h80, rand_line());
        applyStimulus(20);
        issue(0, 1'b1, 32'hC0, rand_line());
        issue(1, 1'b0, 32'h1C0, rand_line());
        applyStimulus(20);

        // Dcache write-back whose inputs move and whose enable drops mid-flight.
        next_delay = 8;
        issue(1, 1'b1, 32'h2000, rand_line());
        applyStimulus(3);
        drv_addr[1]  = 32'h3000;
        drv_write[1] = 1'b0;
        drv_data[1]  = rand_line();
        drop_en[1]   = 1'b1;
        applyStimulus(15);

        // Reset on the fifth BUSY cycle, then a late memory ack.
        next_delay = 50;
        issue(0, 1'b0, 32'h500, '0);
        applyStimulus(5);
        do_rst = 1'b1;
        applyStimulus(1);
        do_rst    = 1'b0;
        force_ack = 1'b1;
        applyStimulus(1);
        force_ack = 1'b0;
        applyStimulus(3);

        // Spurious acks in IDLE, then a normal request must start on time.
        force_ack = 1'b1;
        applyStimulus(2);
        force_ack  = 1'b0;
        next_delay = 2;
        issue(1, 1'b0, 32'h600, '0);
        applyStimulus(8);

        // Timeout: ack only on BUSY cycle 80.
        next_delay = 79;
        issue(0, 1'b0, 32'h700, '0);
        applyStimulus(90);

        // Randomised traffic with moving requester inputs and stray acks.
        rand_delay = 1'b1;
        scramble   = 1'b1;
        spurious   = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!outstanding[p] && $urandom_range(2) == 0)
                    issue(p, 1'($urandom_range(1)), $urandom, rand_line());
            end
            applyStimulus(1);
        end

        guard = 0;
        while ((busy || outstanding[0] || outstanding[1]) && guard < 200) begin
            applyStimulus(1);
            guard++;
        end
        checkOutput("drain_bound", DW'(busy || outstanding[0] || outstanding[1]), '0);
        applyStimulus(4);
        checkOutput("mem_q_left", DW'(mem_q.size()), '0);
        checkOutput("ack_q_left", DW'(ack_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
